fp_addsub_param: RTL and testbench

FP_ADDSUB_PARAM -- requirements
Module: fp_addsub_param

---
 rtl/fp_addsub_param.sv | 207 ++++++++++++++++++++
 tb/tb_fp_addsub_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_param.sv
// Multi-cycle floating-point adder/subtractor with parameterised exponent and fraction widths.
// One operation in flight: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
module fp_addsub_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic                 sub,
  input  logic                 round_mode,
  input  logic                 start,
  input  logic                 ready_in,
  output logic                 ready_out,
  output logic                 valid_out,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]           flags
);
  localparam int E  = EXP_W;
  localparam int M  = MAN_W;
  localparam int W  = 1 + E + M;
  localparam int EW = E + 1;
  localparam int MW = M + 4;
  localparam int SW = M + 5;
  localparam int RW = EW + M;

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  a_q, b_q;
  logic          sub_q, rm_q;
  logic          sa_q, sb_q;
  logic [E-1:0]  ea_q, eb_q;
  logic [M:0]    ma_q, mb_q;
  logic          sign_big_q, eff_sub_q;
  logic [E-1:0]  exp_big_q;
  logic [MW-1:0] man_big_q, man_sml_q;
  logic [SW-1:0] sum_q;
  logic [EW-1:0] exp_n_q;
  logic [MW-1:0] man_n_q;

  logic [E-1:0] ea_raw, eb_raw;
  logic [M-1:0] fa, fb;
  logic         sb_eff, a_nan, b_nan, a_inf, b_inf;

  assign ea_raw = a_q[W-2:M];
  assign eb_raw = b_q[W-2:M];
  assign fa     = a_q[M-1:0];
  assign fb     = b_q[M-1:0];
  assign sb_eff = b_q[W-1] ^ sub_q;
  assign a_nan  = (&ea_raw) && (|fa);
  assign b_nan  = (&eb_raw) && (|fb);
  assign a_inf  = (&ea_raw) && !(|fa);
  assign b_inf  = (&eb_raw) && !(|fb);

  // Pick the larger magnitude, shift the smaller right; everything shifted out folds into sticky.
  logic          a_ge, lost;
  logic [E-1:0]  e_big, e_sml;
  logic [M:0]    m_big, m_sml;
  logic [31:0]   diff, shamt;
  logic [MW-1:0] ext, mask, aligned;

  always_comb begin
    a_ge    = {ea_q, ma_q} >= {eb_q, mb_q};
    e_big   = a_ge ? ea_q : eb_q;
    e_sml   = a_ge ? eb_q : ea_q;
    m_big   = a_ge ? ma_q : mb_q;
    m_sml   = a_ge ? mb_q : ma_q;
    diff    = 32'(e_big) - 32'(e_sml);
    shamt   = (diff > 32'(M + 3)) ? 32'(M + 3) : diff;
    ext     = {m_sml, 3'b000};
    mask    = {MW{1'b1}} << shamt;
    lost    = |(ext & ~mask);
    aligned = (ext >> shamt) | MW'(lost);
  end

  logic [SW-1:0] sum_d;
  assign sum_d = eff_sub_q ? ({1'b0, man_big_q} - {1'b0, man_sml_q})
                           : ({1'b0, man_big_q} + {1'b0, man_sml_q});

  // Left shift is capped so the exponent never drops below 1; a clear hidden bit then means subnormal.
  logic [31:0]   lz, lim, sh;
  logic [MW-1:0] man_n_d;
  logic [EW-1:0] exp_n_d;

  always_comb begin
    lz = 32'(MW);
    for (int i = 0; i < MW; i++)
      if (sum_q[i]) lz = 32'(MW - 1 - i);
    lim     = 32'(exp_big_q) - 32'd1;
    sh      = (lz < lim) ? lz : lim;
    man_n_d = sum_q[MW-1:0] << sh;
    exp_n_d = EW'(32'(exp_big_q) - sh);
    if (sum_q[SW-1]) begin
      man_n_d = sum_q[SW-1:1] | MW'(sum_q[0]);
      exp_n_d = {1'b0, exp_big_q} + EW'(1);
    end else if (!man_n_d[MW-1]) begin
      exp_n_d = '0;
    end
  end

  // Rounding increments {exponent, fraction} as one field, so mantissa carry bumps the exponent.
  logic          g, r, s, inexact, up, ovf, zero_sum, sign_f, invalid;
  logic [RW-1:0] rnd_sum;
  logic [EW-1:0] exp_f;
  logic [W-1:0]  res_d;
  logic [4:0]    flg_d;

  always_comb begin
    g        = man_n_q[2];
    r        = man_n_q[1];
    s        = man_n_q[0];
    inexact  = g | r | s;
    up       = !rm_q && g && (r | s | man_n_q[3]);
    rnd_sum  = {exp_n_q, man_n_q[MW-2:3]} + RW'(up);
    exp_f    = rnd_sum[RW-1:M];
    ovf      = exp_f >= EW'({E{1'b1}});
    zero_sum = (man_n_q == '0);
    sign_f   = zero_sum ? (sa_q & sb_q) : sign_big_q;
    invalid  = a_nan | b_nan | (a_inf & b_inf & (a_q[W-1] ^ sb_eff));
    res_d    = {sign_f, exp_f[E-1:0], rnd_sum[M-1:0]};
    flg_d    = {3'b000, (exp_f == '0) && inexact, inexact};
    if (invalid) begin
      res_d = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      flg_d = 5'b10000;
    end else if (a_inf) begin
      res_d = {a_q[W-1], {E{1'b1}}, {M{1'b0}}};
      flg_d = 5'b00000;
    end else if (b_inf) begin
      res_d = {sb_eff, {E{1'b1}}, {M{1'b0}}};
      flg_d = 5'b00000;
    end else if (ovf) begin
      res_d = {sign_f, {E{1'b1}}, {M{1'b0}}};
      flg_d = 5'b00101;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = UNPACK;
      UNPACK:  state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_out = (state == IDLE);
    valid_out = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0; b_q <= '0; sub_q <= 1'b0; rm_q <= 1'b0;
      sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      sign_big_q <= 1'b0; eff_sub_q <= 1'b0; exp_big_q <= '0;
      man_big_q <= '0; man_sml_q <= '0; sum_q <= '0;
      exp_n_q <= '0; man_n_q <= '0;
      result <= '0; flags <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_q   <= op_a;
          b_q   <= op_b;
          sub_q <= sub;
          rm_q  <= round_mode;
        end
        UNPACK: begin
          sa_q <= a_q[W-1];
          sb_q <= sb_eff;
          ea_q <= (ea_raw == '0) ? E'(1) : ea_raw;
          eb_q <= (eb_raw == '0) ? E'(1) : eb_raw;
          ma_q <= {|ea_raw, fa};
          mb_q <= {|eb_raw, fb};
        end
        ALIGN: begin
          sign_big_q <= a_ge ? sa_q : sb_q;
          eff_sub_q  <= sa_q ^ sb_q;
          exp_big_q  <= e_big;
          man_big_q  <= {m_big, 3'b000};
          man_sml_q  <= aligned;
        end
        ADD:  sum_q <= sum_d;
        NORM: begin
          exp_n_q <= exp_n_d;
          man_n_q <= man_n_d;
        end
        ROUND: begin
          result <= res_d;
          flags  <= flg_d;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_param.sv
// Scoreboard bench for fp_addsub_param: single-precision and half-precision instances,
// directed vectors with hand-computed results, a decoupled monitor per instance.
module tb_fp_addsub_param;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] op_a, op_b, result;
  logic        sub, round_mode, start, ready_in, ready_out, valid_out;
  logic [4:0]  flags;
  logic [15:0] op_a_h, op_b_h, result_h;
  logic        sub_h, rm_h, start_h, ready_in_h, ready_out_h, valid_out_h;
  logic [4:0]  flags_h;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;
  exp_t sb_f[$];
  exp_t sb_h[$];
  exp_t mon_f, mon_h;

  fp_addsub_param dut (
    .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b), .sub(sub),
    .round_mode(round_mode), .start(start), .ready_in(ready_in),
    .ready_out(ready_out), .valid_out(valid_out), .result(result), .flags(flags)
  );

  fp_addsub_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .op_a(op_a_h), .op_b(op_b_h), .sub(sub_h),
    .round_mode(rm_h), .start(start_h), .ready_in(ready_in_h),
    .ready_out(ready_out_h), .valid_out(valid_out_h), .result(result_h), .flags(flags_h)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Issue one operation, push its expected response, then measure the accept-to-valid latency.
  task automatic applyStimulus(input bit half, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic rm,
                               input logic [31:0] er, input logic [4:0] ef);
    int   cyc;
    logic got;
    cyc = 0;
    @(posedge clk); #1;
    while (!(half ? ready_out_h : ready_out) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("idle_wait", 32'(half ? ready_out_h : ready_out), 32'd1);
    if (half) begin
      op_a_h = a[15:0]; op_b_h = b[15:0]; sub_h = s; rm_h = rm; start_h = 1'b1;
      sb_h.push_back('{res: er, flg: ef});
    end else begin
      op_a = a; op_b = b; sub = s; round_mode = rm; start = 1'b1;
      sb_f.push_back('{res: er, flg: ef});
    end
    @(posedge clk); #1;
    start = 1'b0; start_h = 1'b0;
    op_a = ~a; op_b = ~b; sub = ~s; round_mode = ~rm;
    op_a_h = ~a[15:0]; op_b_h = ~b[15:0]; sub_h = ~s; rm_h = ~rm;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = half ? valid_out_h : valid_out;
    end
    checkOutput("latency", 32'(cyc), 32'd6);
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in) begin
      if (sb_f.size() == 0) begin
        n_cmp++; n_err++;
        $display("[TB] FAIL f_unexpected: got valid_out=1 want no pending result");
      end else begin
        mon_f = sb_f.pop_front();
        checkOutput("f_result", result, mon_f.res);
        checkOutput("f_flags", 32'(flags), 32'(mon_f.flg));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid_out_h && ready_in_h) begin
      if (sb_h.size() == 0) begin
        n_cmp++; n_err++;
        $display("[TB] FAIL h_unexpected: got valid_out=1 want no pending result");
      end else begin
        mon_h = sb_h.pop_front();
        checkOutput("h_result", 32'(result_h), mon_h.res);
        checkOutput("h_flags", 32'(flags_h), 32'(mon_h.flg));
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   cyc;
    logic got;
    rst_n = 1'b0; ready_in = 1'b1; ready_in_h = 1'b1;
    start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; round_mode = 1'b0;
    start_h = 1'b0; op_a_h = '0; op_b_h = '0; sub_h = 1'b0; rm_h = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 32'(ready_out), 32'd1);
    checkOutput("rst_valid", 32'(valid_out), 32'd0);
    checkOutput("rst_result", result, 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    checkOutput("rst_ready_h", 32'(ready_out_h), 32'd1);
    checkOutput("rst_valid_h", 32'(valid_out_h), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(ready_out), 32'd1);

    applyStimulus(0, 32'h41A60000, 32'h40100000, 1, 0, 32'h41940000, 5'b00000);
    applyStimulus(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 1, 32'h7F800000, 5'b00101);
    applyStimulus(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0, 32'h7F800000, 5'b00101);
    applyStimulus(0, 32'hFF800000, 32'hFF800000, 1, 0, 32'h7FC00000, 5'b10000);
    applyStimulus(0, 32'h00000040, 32'h00000003, 1, 1, 32'h0000003D, 5'b00000);
    applyStimulus(0, 32'h3F800000, 32'h33800000, 0, 0, 32'h3F800000, 5'b00001);
    applyStimulus(0, 32'h3F800001, 32'h33800000, 0, 0, 32'h3F800002, 5'b00001);
    applyStimulus(0, 32'h3F800000, 32'h33800001, 0, 0, 32'h3F800001, 5'b00001);
    applyStimulus(0, 32'h3F800000, 32'h33800001, 0, 1, 32'h3F800000, 5'b00001);
    applyStimulus(0, 32'h3F800000, 32'h3F800000, 1, 0, 32'h00000000, 5'b00000);
    applyStimulus(0, 32'h3F800000, 32'hBF800000, 0, 1, 32'h00000000, 5'b00000);
    applyStimulus(0, 32'h80000000, 32'h80000000, 0, 0, 32'h80000000, 5'b00000);
    applyStimulus(0, 32'h80000000, 32'h00000000, 1, 0, 32'h80000000, 5'b00000);
    applyStimulus(0, 32'h7F800000, 32'h3F800000, 0, 0, 32'h7F800000, 5'b00000);
    applyStimulus(0, 32'h3F800000, 32'h7F800000, 1, 0, 32'hFF800000, 5'b00000);
    applyStimulus(0, 32'h7FA00000, 32'h3F800000, 0, 0, 32'h7FC00000, 5'b10000);
    applyStimulus(0, 32'h00400000, 32'h00400000, 0, 0, 32'h00800000, 5'b00000);
    applyStimulus(0, 32'h40000000, 32'h40400000, 1, 0, 32'hBF800000, 5'b00000);
    applyStimulus(0, 32'h3F800000, 32'h3F7FFFFF, 1, 0, 32'h33800000, 5'b00000);

    applyStimulus(1, 32'h3C00, 32'h3C00, 0, 0, 32'h4000, 5'b00000);
    applyStimulus(1, 32'h7C00, 32'h7C00, 1, 0, 32'h7E00, 5'b10000);
    applyStimulus(1, 32'h3C00, 32'h4000, 1, 0, 32'hBC00, 5'b00000);
    applyStimulus(1, 32'h7BFF, 32'h7BFF, 0, 1, 32'h7C00, 5'b00101);

    // Consumer stalls in DONE while start is pulsed in busy states.
    @(posedge clk); #1;
    ready_in = 1'b0;
    op_a = 32'h40000000; op_b = 32'h40000000; sub = 1'b0; round_mode = 1'b0; start = 1'b1;
    sb_f.push_back('{res: 32'h40800000, flg: 5'b00000});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op_a = 32'h3F800000; op_b = 32'h3F800000;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = valid_out;
    end
    checkOutput("hold_reached", 32'(got), 32'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("hold_valid", 32'(valid_out), 32'd1);
      checkOutput("hold_result", result, 32'h40800000);
      checkOutput("hold_flags", 32'(flags), 32'd0);
      checkOutput("hold_ready_out", 32'(ready_out), 32'd0);
      @(posedge clk); #1;
      start = (k % 2 == 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    start = 1'b0;
    ready_in = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("no_phantom_valid", 32'(valid_out), 32'd0);
    checkOutput("hold_sb_drained", 32'(sb_f.size()), 32'd0);

    // Reset asserted while the operation sits in ALIGN.
    @(posedge clk); #1;
    op_a = 32'h40400000; op_b = 32'h3F800000; sub = 1'b0; round_mode = 1'b0; start = 1'b1;
    sb_f.push_back('{res: 32'h40800000, flg: 5'b00000});
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(valid_out), 32'd0);
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_flags", 32'(flags), 32'd0);
    checkOutput("midrst_ready", 32'(ready_out), 32'd1);
    sb_f.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postrst_ready", 32'(ready_out), 32'd1);
    checkOutput("postrst_valid", 32'(valid_out), 32'd0);
    checkOutput("postrst_result", result, 32'd0);
    applyStimulus(0, 32'h40400000, 32'h3F800000, 0, 0, 32'h40800000, 5'b00000);

    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("f_sb_empty", 32'(sb_f.size()), 32'd0);
    checkOutput("h_sb_empty", 32'(sb_h.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
